rbm_sampler: RTL and testbench

RBM_SAMPLER -- requirements
Module: rbm_sampler

---
 rtl/rbm_sampler_if.sv | 11 +
 rtl/rbm_sampler.sv | 104 ++++++++++
 tb/tb_rbm_sampler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rbm_sampler_if.sv
// rbm_sampler_if: core-to-sampler handshake plus the sampled-state output bus.
interface rbm_sampler_if #(
    parameter int NUM_N = 3,
    parameter int BW_PS = 16
);
    logic en, done, receive, busy, overrun;
    logic [BW_PS*NUM_N-1:0] ps_data;
    logic [NUM_N-1:0] new_states, new_states_en;
    modport master (output en, done, ps_data, input receive, new_states, new_states_en, busy, overrun);
    modport slave (input en, done, ps_data, output receive, new_states, new_states_en, busy, overrun);
endinterface

// File: rtl/rbm_sampler.sv
// rbm_sampler: turns RBM partial sums into stochastic binary states, LANES neurons per cycle.
// Each lane owns an 8-bit LFSR; neuron i fires when lfsr[i mod LANES] <= clamp(128 + ps_i>>>SHIFT).
module rbm_sampler #(
    parameter int NUM_N = 3,
    parameter int BW_PS = 16,
    parameter int LANES = 2,
    parameter int SHIFT = 4,
    parameter int LAT = 4
) (
    input logic clk,
    input logic rst,
    rbm_sampler_if.slave bus
);
    localparam int NG = (NUM_N + LANES - 1) / LANES;
    localparam int GW = $clog2(NG + 1);
    localparam int CW = 4;
    localparam logic signed [BW_PS:0] HALF = 128;
    typedef enum logic [1:0] {IDLE, ACK, WAIT, EMIT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [BW_PS*NUM_N-1:0] ps_q, ps_d;
    logic [7:0] lfsr_q [LANES];
    logic [7:0] lfsr_d [LANES];
    logic receive_q, receive_d, busy_q, busy_d, overrun_q, overrun_d;
    logic [NUM_N-1:0] ns_q, ns_d, nse_q, nse_d;
    logic signed [BW_PS:0] ext [NUM_N];
    logic signed [BW_PS:0] sum [NUM_N];
    logic [7:0] prob [NUM_N];
    always_comb begin
        for (int i = 0; i < NUM_N; i++) begin
            ext[i] = {ps_q[i*BW_PS+BW_PS-1], ps_q[i*BW_PS +: BW_PS]};
            sum[i] = (ext[i] >>> SHIFT) + HALF;
            prob[i] = sum[i] < 0 ? 8'd0 : sum[i] > 255 ? 8'd255 : sum[i][7:0];
        end
    end
    // Outputs are computed from the next state so the registered values line up with state_q.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        grp_d = grp_q;
        ps_d = ps_q;
        overrun_d = overrun_q | (bus.done && state_q != IDLE);
        unique case (state_q)
            IDLE: if (bus.done) begin
                state_d = ACK;
                ps_d = bus.ps_data;
            end
            ACK: begin
                state_d = LAT == 0 ? EMIT : WAIT;
                cnt_d = '0;
                grp_d = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                state_d = cnt_q == CW'(LAT - 1) ? EMIT : WAIT;
            end
            EMIT: begin
                grp_d = grp_q + 1'b1;
                state_d = grp_q == GW'(NG - 1) ? IDLE : EMIT;
            end
        endcase
        receive_d = state_d == ACK;
        busy_d = state_d != IDLE;
        ns_d = '0;
        nse_d = '0;
        for (int i = 0; i < NUM_N; i++) begin
            nse_d[i] = state_d == EMIT && grp_d == GW'(i / LANES);
            ns_d[i] = nse_d[i] && lfsr_q[i % LANES] <= prob[i];
        end
        for (int l = 0; l < LANES; l++)
            lfsr_d[l] = state_d == EMIT ? {lfsr_q[l][6:0], lfsr_q[l][7] ^ lfsr_q[l][5] ^ lfsr_q[l][4] ^ lfsr_q[l][3]} : lfsr_q[l];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            grp_q <= '0;
            ps_q <= '0;
            receive_q <= 1'b0;
            busy_q <= 1'b0;
            overrun_q <= 1'b0;
            ns_q <= '0;
            nse_q <= '0;
            for (int l = 0; l < LANES; l++) lfsr_q[l] <= 8'hA5 ^ 8'(l);
        end else if (bus.en) begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            grp_q <= grp_d;
            ps_q <= ps_d;
            receive_q <= receive_d;
            busy_q <= busy_d;
            overrun_q <= overrun_d;
            ns_q <= ns_d;
            nse_q <= nse_d;
            lfsr_q <= lfsr_d;
        end
    end
    assign bus.receive = receive_q;
    assign bus.busy = busy_q;
    assign bus.overrun = overrun_q;
    assign bus.new_states = ns_q;
    assign bus.new_states_en = nse_q;
endmodule

// File: tb/tb_rbm_sampler.sv
// tb_rbm_sampler: directed checks of rbm_sampler timing, overrun, reset abort, enable stall and LFSR sampling.
module tb_rbm_sampler;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] m_lfsr [2];
    int ones [2];
    logic b0, b1, b2;
    localparam logic [47:0] P1 = {16'sd4000, -16'sd4000, 16'sd4000};
    localparam logic [47:0] P2 = {-16'sd4000, 16'sd4000, -16'sd4000};
    rbm_sampler_if #(.NUM_N(3), .BW_PS(16)) bus ();
    rbm_sampler #(.NUM_N(3), .BW_PS(16), .LANES(2), .SHIFT(4), .LAT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask
    task automatic start(input logic [47:0] ps);
        bus.ps_data = ps;
        bus.done = 1'b1;
        step(1);
        bus.done = 1'b0;
    endtask
    function automatic logic [7:0] nxt(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction
    initial begin
        bus.en = 1'b1;
        bus.done = 1'b0;
        bus.ps_data = '0;
        rst = 1'b1;
        step(2);
        chk("rst_receive", bus.receive, 0);
        chk("rst_states", bus.new_states, 0);
        chk("rst_states_en", bus.new_states_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_lfsr0", dut.lfsr_q[0], 8'hA5);
        chk("rst_lfsr1", dut.lfsr_q[1], 8'hA4);
        rst = 1'b0;
        step(1);
        // basic transfer timing
        start(P1);
        chk("t1_receive", bus.receive, 1);
        chk("t1_busy", bus.busy, 1);
        step(1);
        chk("t2_receive_low", bus.receive, 0);
        step(4);
        chk("t6_en", bus.new_states_en, 3'b011);
        chk("t6_st", bus.new_states, 3'b001);
        step(1);
        chk("t7_en", bus.new_states_en, 3'b100);
        chk("t7_st", bus.new_states, 3'b100);
        step(1);
        chk("t8_busy", bus.busy, 0);
        chk("t8_en", bus.new_states_en, 0);
        chk("t8_overrun", bus.overrun, 0);
        // done pulse during WAIT
        start(P2);
        step(2);
        bus.done = 1'b1;
        step(1);
        bus.done = 1'b0;
        chk("ov_no_receive", bus.receive, 0);
        step(2);
        chk("ov_t6_en", bus.new_states_en, 3'b011);
        chk("ov_t6_st", bus.new_states, 3'b010);
        step(1);
        chk("ov_t7_en", bus.new_states_en, 3'b100);
        chk("ov_t7_st", bus.new_states, 3'b000);
        step(1);
        chk("ov_t8_busy", bus.busy, 0);
        chk("ov_sticky", bus.overrun, 1);
        step(3);
        chk("ov_sticky_later", bus.overrun, 1);
        do_reset();
        chk("ov_cleared", bus.overrun, 0);
        // reset during first EMIT cycle
        start(P1);
        step(5);
        chk("ab_t6_en", bus.new_states_en, 3'b011);
        #2 rst = 1'b1;
        step(1);
        chk("ab_states_en", bus.new_states_en, 0);
        chk("ab_states", bus.new_states, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_receive", bus.receive, 0);
        rst = 1'b0;
        step(3);
        chk("ab_no_group2", bus.new_states_en, 0);
        chk("ab_idle", bus.busy, 0);
        // enable stall of 3 cycles during WAIT
        start(P1);
        step(1);
        bus.en = 1'b0;
        step(3);
        chk("st_busy_hold", bus.busy, 1);
        bus.en = 1'b1;
        step(3);
        chk("st_t8_none", bus.new_states_en, 0);
        step(1);
        chk("st_t9_en", bus.new_states_en, 3'b011);
        chk("st_t9_st", bus.new_states, 3'b001);
        step(1);
        chk("st_t10_en", bus.new_states_en, 3'b100);
        chk("st_t10_st", bus.new_states, 3'b100);
        step(1);
        chk("st_t11_busy", bus.busy, 0);
        // receive pulse extends while en is low
        start(P1);
        bus.en = 1'b0;
        step(2);
        chk("rx_hold", bus.receive, 1);
        bus.en = 1'b1;
        step(1);
        chk("rx_release", bus.receive, 0);
        step(8);
        chk("rx_done", bus.busy, 0);
        // prob=128 over a full LFSR period
        do_reset();
        m_lfsr[0] = 8'hA5;
        m_lfsr[1] = 8'hA4;
        ones[0] = 0;
        ones[1] = 0;
        for (int k = 0; k < 255; k++) begin
            start(48'd0);
            step(5);
            b0 = m_lfsr[0] <= 8'd128;
            b1 = m_lfsr[1] <= 8'd128;
            m_lfsr[0] = nxt(m_lfsr[0]);
            m_lfsr[1] = nxt(m_lfsr[1]);
            chk("lf_g0", {bus.new_states_en, bus.new_states}, {3'b011, 1'b0, b1, b0});
            ones[0] += int'(bus.new_states[0]);
            ones[1] += int'(bus.new_states[1]);
            step(1);
            b2 = m_lfsr[0] <= 8'd128;
            m_lfsr[0] = nxt(m_lfsr[0]);
            m_lfsr[1] = nxt(m_lfsr[1]);
            chk("lf_g1", {bus.new_states_en, bus.new_states}, {3'b100, b2, 2'b00});
            step(1);
        end
        chk("lf_ones_lane0", ones[0], 128);
        chk("lf_ones_lane1", ones[1], 128);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
